// File: rtl/sa_result_drain.sv
// sa_result_drain: snapshots the systolic-array result bus on a strobe
// and streams it out row-major, one word per valid/ready transfer.
module sa_result_drain #(
  parameter int WIDTH = 32,
  parameter int HPE   = 8,
  parameter int VPE   = 8,
  localparam int RW   = (VPE > 1) ? $clog2(VPE) : 1,
  localparam int CW   = (HPE > 1) ? $clog2(HPE) : 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [2*WIDTH*HPE*VPE-1:0]    Y,
  input  logic                          y_valid,
  output logic [2*WIDTH-1:0]            res_data,
  output logic [RW-1:0]                 res_row,
  output logic [CW-1:0]                 res_col,
  output logic                          res_last,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic                          busy,
  output logic [7:0]                    drop_cnt,
  output logic [15:0]                   frame_cnt
);

  localparam int N  = HPE * VPE;
  localparam int DW = 2 * WIDTH;
  localparam int TW = DW * N;
  localparam int PW = $clog2(N) + 1;

  localparam logic [CW-1:0] COL_MAX  = CW'(HPE - 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(N - 1);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t          state;
  logic [TW-1:0]   snap;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_inc;
  logic [CW-1:0]   col_nxt;
  logic [RW-1:0]   row_nxt;
  logic            col_wrap;

  // Position of the word after the one currently presented.
  always_comb begin
    ptr_inc  = ptr + PW'(1);
    col_wrap = (res_col == COL_MAX);
    col_nxt  = col_wrap ? '0 : res_col + CW'(1);
    row_nxt  = col_wrap ? res_row + RW'(1) : res_row;
  end

  // Capture/drain FSM; the snapshot shifts left so its top slice is
  // always the next word to present.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      snap      <= '0;
      ptr       <= '0;
      res_data  <= '0;
      res_row   <= '0;
      res_col   <= '0;
      res_last  <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      drop_cnt  <= '0;
      frame_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (y_valid) begin
            state     <= DRAIN;
            res_data  <= Y[TW-1 -: DW];
            snap      <= Y << DW;
            ptr       <= '0;
            res_row   <= '0;
            res_col   <= '0;
            res_last  <= (N == 1);
            res_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        DRAIN: begin
          if (res_ready && res_last) begin
            frame_cnt <= frame_cnt + 16'd1;
            if (y_valid) begin
              res_data <= Y[TW-1 -: DW];
              snap     <= Y << DW;
              ptr      <= '0;
              res_row  <= '0;
              res_col  <= '0;
              res_last <= (N == 1);
            end else begin
              state     <= IDLE;
              res_valid <= 1'b0;
              busy      <= 1'b0;
              res_last  <= 1'b0;
            end
          end else begin
            if (y_valid && drop_cnt != 8'hFF)
              drop_cnt <= drop_cnt + 8'd1;
            if (res_ready) begin
              res_data <= snap[TW-1 -: DW];
              snap     <= snap << DW;
              ptr      <= ptr_inc;
              res_row  <= row_nxt;
              res_col  <= col_nxt;
              res_last <= (ptr_inc == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
